// File: rtl/mul_scheduler.sv
// mul_scheduler: arbitrates N requesters onto one serial multiplier.
// For each operation it grants a round-robin winner, refills the random
// buffer from the stream, starts the multiplier, checks that the done pulse
// arrives at the fixed latency W, and returns the result to the winner.
module mul_scheduler #(
   parameter  int unsigned d = 2,
   parameter  int unsigned N = 4,
   localparam int unsigned W = 8 + d
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N-1:0]          req_valid,
   input  logic [N-1:0][W-1:0]   req_p1,
   input  logic [N-1:0][W-1:0]   req_p2,
   output logic [N-1:0]          req_grant,
   output logic [N-1:0]          rsp_valid,
   output logic [W-1:0]          rsp_out,
   input  logic                  rnd_valid,
   input  logic [d-1:0]          rnd_data,
   output logic                  rnd_ready,
   output logic                  mul_drdy_i,
   output logic [W-1:0]          mul_p1,
   output logic [W-1:0]          mul_p2,
   output logic [2*W-1:0][d-1:0] mul_random_vect,
   input  logic [W-1:0]          mul_out,
   input  logic                  mul_drdy_o,
   output logic                  err
);

   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned FW = $clog2(2 * W);
   localparam int unsigned CW = $clog2(W + 2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t                 r_state;
   state_t                 w_next;

   logic                   w_any;
   logic [IW-1:0]          w_win;
   logic [IW-1:0]          r_last;
   logic [IW-1:0]          r_idx;

   logic [W-1:0]           r_p1;
   logic [W-1:0]           r_p2;
   logic [2*W-1:0][d-1:0]  r_buf;
   logic [FW-1:0]          r_fill;
   logic [CW-1:0]          r_cnt;
   logic [W-1:0]           r_result;
   logic                   r_err;
   logic                   r_ignore_done;

   logic                   w_fill_last;
   logic                   w_done_ok;
   logic                   w_timeout;

   // r_cnt is 0 in the first WAIT cycle, so the cycle W after issue is W-1
   assign w_fill_last = (r_fill == FW'(2 * W - 1));
   assign w_done_ok   = (r_cnt == CW'(W - 1));
   assign w_timeout   = (r_cnt == CW'(W + 1));

   assign rsp_out         = r_result;
   assign mul_p1          = r_p1;
   assign mul_p2          = r_p2;
   assign mul_random_vect = r_buf;
   assign err             = r_err;

   // Round-robin search starting at the requester after the last winner
   always_comb begin
      int unsigned   v_k;
      logic [IW-1:0] v_sel;
      w_any = 1'b0;
      w_win = '0;
      v_k   = 0;
      v_sel = '0;
      for (int unsigned i = 0; i < N; i++) begin
         v_k = 32'(r_last) + 32'd1 + i;
         if (v_k >= N) begin
            v_k = v_k - N;
         end
         v_sel = IW'(v_k);
         if (!w_any && req_valid[v_sel]) begin
            w_any = 1'b1;
            w_win = v_sel;
         end
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (w_any) w_next = S_FILL;
         end
         S_FILL: begin
            if (rnd_valid && w_fill_last) w_next = S_ISSUE;
         end
         S_ISSUE: begin
            w_next = S_WAIT;
         end
         S_WAIT: begin
            if (mul_drdy_o) begin
               w_next = w_done_ok ? S_RESP : S_IDLE;
            end else if (w_timeout) begin
               w_next = S_IDLE;
            end
         end
         S_RESP: begin
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Output decode: grant is the only output that also depends on inputs
   always_comb begin
      req_grant  = '0;
      rsp_valid  = '0;
      rnd_ready  = 1'b0;
      mul_drdy_i = 1'b0;
      unique case (r_state)
         S_IDLE:  if (w_any && !rst) req_grant[w_win] = 1'b1;
         S_FILL:  rnd_ready = 1'b1;
         S_ISSUE: mul_drdy_i = 1'b1;
         S_RESP:  rsp_valid[r_idx] = 1'b1;
         default: ;
      endcase
   end

   // Capture the winner's operands and advance the round-robin pointer
   always_ff @(posedge clk) begin
      if (rst) begin
         r_last <= IW'(N - 1);
         r_idx  <= '0;
         r_p1   <= '0;
         r_p2   <= '0;
      end else if (r_state == S_IDLE && w_any) begin
         r_last <= w_win;
         r_idx  <= w_win;
         r_p1   <= req_p1[w_win];
         r_p2   <= req_p2[w_win];
      end
   end

   // Random buffer refill, one entry per accepted stream word
   always_ff @(posedge clk) begin
      if (rst) begin
         r_buf  <= '0;
         r_fill <= '0;
      end else if (r_state == S_IDLE) begin
         r_fill <= '0;
      end else if (r_state == S_FILL && rnd_valid) begin
         r_buf[r_fill] <= rnd_data;
         r_fill        <= r_fill + FW'(1);
      end
   end

   // Latency counter, result latch and sticky protocol error
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt         <= '0;
         r_result      <= '0;
         r_err         <= 1'b0;
         r_ignore_done <= 1'b1;
      end else begin
         if (r_state == S_ISSUE) begin
            r_cnt         <= '0;
            r_ignore_done <= 1'b0;
         end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt + CW'(1);
         end
         if (r_state == S_WAIT) begin
            if (mul_drdy_o) begin
               if (w_done_ok) begin
                  r_result <= mul_out;
               end else begin
                  r_err <= 1'b1;
               end
            end else if (w_timeout) begin
               r_err <= 1'b1;
            end
         end else if (mul_drdy_o && !r_ignore_done) begin
            // a done left over from an operation aborted by rst is harmless
            r_err <= 1'b1;
         end
      end
   end

endmodule

// File: doc/mul_scheduler.md
MUL_SCHEDULER -- requirements
Module: mul_scheduler

Interface
REQ-001 Parameter d, default 2, redundancy degree; operand/state width W = 8+d bits, random word width d bits.
REQ-002 Parameter N, default 4, number of requesters (2..8).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  N  per-requester multiplication request.
REQ-006 req_p1, req_p2  input  N x W  per-requester operands, sampled on grant.
REQ-007 req_grant  output  N  one-hot, one-cycle pulse when a requester's operands are captured.
REQ-008 rsp_valid  output  N  one-hot, one-cycle pulse marking the result for that requester.
REQ-009 rsp_out  output  W  result shared by all requesters, valid while rsp_valid nonzero.
REQ-010 rnd_valid / rnd_data / rnd_ready  input / input d / output  random word stream; transfer when valid and ready are both high.
REQ-011 mul_drdy_i  output  1  start pulse to the serial multiplier.
REQ-012 mul_p1, mul_p2  output  W each  multiplier operands, held stable from start until done.
REQ-013 mul_random_vect  output  2W x d  random vector to the multiplier, held stable from start until done.
REQ-014 mul_out / mul_drdy_o  input W / input 1  multiplier result and done pulse.
REQ-015 err  output  1  sticky protocol error flag.

Function
REQ-016 FSM states: IDLE, FILL, ISSUE, WAIT, RESP.
REQ-017 IDLE: if any req_valid, grant the round-robin winner (priority starts at index after last winner), capture its p1/p2, pulse req_grant, go to FILL.
REQ-018 FILL: rnd_ready high; each transfer writes rnd_data to entry k of the random buffer, k = 0..2W-1 ascending; after the entry 2W-1 transfer go to ISSUE.
REQ-019 FILL stalls indefinitely while rnd_valid low; no timeout.
REQ-020 rnd_ready low in every state except FILL; the buffer is fully refilled for every multiplication, and no random word is reused.
REQ-021 ISSUE: pulse mul_drdy_i for exactly one cycle, clear the cycle counter, go to WAIT.
REQ-022 WAIT: the counter increments each cycle; on mul_drdy_o, latch mul_out into the result register and go to RESP.
REQ-023 mul_drdy_o is required exactly W cycles after the mul_drdy_i cycle; if it arrives earlier, or has not arrived by cycle W+2, set err and return to IDLE without rsp_valid.
REQ-024 A mul_drdy_o outside WAIT sets err and is otherwise ignored.
REQ-025 RESP: pulse rsp_valid for the granted index for one cycle with rsp_out = latched result, then go to IDLE.
REQ-026 rsp_out holds its last value between responses.
REQ-027 The minimum request-to-response latency is 1 (grant) + 2W (fill) + 1 (issue) + W + 1 (resp) cycles, with rnd_valid held high.
REQ-028 A requester keeping req_valid high after rsp_valid is a new request; it competes in round-robin and does not win twice while others wait.
REQ-029 Changes to req_valid or req_p* after the grant do not affect an operation in flight.
REQ-030 At most one operation is in flight; non-granted requesters wait with no grant.

Reset
REQ-031 On rst: state IDLE; req_grant, rsp_valid, rnd_ready, mul_drdy_i and err = 0; rsp_out, mul_p1, mul_p2 and the random buffer = 0; round-robin pointer so requester 0 has top priority.
REQ-032 rst in any state aborts the operation in the next cycle with no response; mul_drdy_o arriving after rst and before any new issue does not set err.
REQ-033 err clears only on rst.

Verification
REQ-034 d=2, N=4, req 1 only, p1=p2=0x001, rnd_valid constant, model multiplier returns 0x2A5 at cycle W=10 -> grant[1] at cycle 1, mul_drdy_i at cycle 22, rsp_valid[1] with rsp_out=0x2A5 at cycle 33.
REQ-035 All four req_valid held high -> grants in order 0,1,2,3,0, and each rsp_valid matches the preceding grant index.
REQ-036 rnd_valid toggled 1-0-1-0 during FILL -> exactly 2W=20 transfers, mul_random_vect entry k equals the k-th transferred word, issue is delayed by the stall cycles.
REQ-037 Model multiplier returns done at cycle 7, or never -> err=1, no rsp_valid, FSM back in IDLE and accepting the next request.
REQ-038 rst asserted during WAIT, then done arrives -> no rsp_valid, err stays 0, next grant goes to requester 0.
